// File: rtl/load_store_unit_if.sv
// Memory-side bus between the load/store unit and a word-addressed memory.
// The unit (master) drives one request at a time and holds it until i_BusReady.
interface load_store_unit_if;
   logic        o_BusReq;
   logic        o_BusWe;
   logic [31:0] o_BusAddr;
   logic [31:0] o_BusWData;
   logic [3:0]  o_BusBE;
   logic        i_BusReady;
   logic [31:0] i_BusRData;

   modport master (
      output o_BusReq, o_BusWe, o_BusAddr, o_BusWData, o_BusBE,
      input  i_BusReady, i_BusRData
   );

   modport slave (
      input  o_BusReq, o_BusWe, o_BusAddr, o_BusWData, o_BusBE,
      output i_BusReady, i_BusRData
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: aligns datapath byte/half/word accesses onto a 32-bit bus.
// Latency: o_Done two cycles after the request at best; stalls the pipe while the bus is busy, with timeout.
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    i_Clk,
   input  logic                    i_Reset,
   input  logic                    i_MemRead,
   input  logic                    i_MemWrite,
   input  logic [2:0]              i_funct3,
   input  logic [31:0]             i_Addr,
   input  logic [31:0]             i_wData,
   output logic [31:0]             o_rData,
   output logic                    o_Stall,
   output logic                    o_Done,
   output logic                    o_MisalignErr,
   output logic                    o_BusErr,
   load_store_unit_if.master       bus
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [31:0]      r_addr;
   logic             r_we;
   logic [3:0]       r_be;
   logic [31:0]      r_wdata;
   logic [2:0]       r_funct3;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_rdata;
   logic             r_err;

   logic             w_req;
   logic             w_misalign;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic             w_start;
   logic             w_capture;
   logic             w_timeout;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;

   // A simultaneous read and write is treated as a store.
   assign w_req = i_MemRead | i_MemWrite;

   // funct3[1:0]: 00 byte, 01 half, anything else handled as a word.
   always_comb begin
      w_misalign = 1'b0;
      w_be       = 4'b1111;
      w_wdata    = i_wData;
      case (i_funct3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << i_Addr[1:0];
            w_wdata = {4{i_wData[7:0]}};
         end
         2'b01: begin
            w_misalign = i_Addr[0];
            w_be       = i_Addr[1] ? 4'b1100 : 4'b0011;
            w_wdata    = {2{i_wData[15:0]}};
         end
         default: begin
            w_misalign = |i_Addr[1:0];
         end
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_capture   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req && !w_misalign) begin
               w_start     = 1'b1;
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (bus.i_BusReady) begin
               w_capture   = 1'b1;
               w_state_nxt = RESP;
            end else if (r_cnt == CNT_LAST) begin
               w_timeout   = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_we     <= 1'b0;
         r_be     <= '0;
         r_wdata  <= '0;
         r_funct3 <= '0;
         r_cnt    <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start) begin
            r_addr   <= i_Addr;
            r_we     <= i_MemWrite;
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_funct3 <= i_funct3;
            r_cnt    <= '0;
            r_err    <= 1'b0;
         end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_capture) begin
            r_rdata <= bus.i_BusRData;
            r_err   <= 1'b0;
         end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
         end
      end
   end

   assign bus.o_BusReq   = (r_state == BUSY);
   assign bus.o_BusWe    = r_we;
   assign bus.o_BusAddr  = {r_addr[31:2], 2'b00};
   assign bus.o_BusBE    = r_be;
   assign bus.o_BusWData = r_wdata;

   assign o_Stall       = !i_Reset && (((r_state == IDLE) && w_req && !w_misalign) || (r_state == BUSY));
   assign o_MisalignErr = (r_state == IDLE) && w_req && w_misalign;
   assign o_Done        = (r_state == RESP);
   assign o_BusErr      = (r_state == RESP) && r_err;

   always_comb begin
      w_byte = r_rdata[7:0];
      case (r_addr[1:0])
         2'b01:   w_byte = r_rdata[15:8];
         2'b10:   w_byte = r_rdata[23:16];
         2'b11:   w_byte = r_rdata[31:24];
         default: w_byte = r_rdata[7:0];
      endcase
      w_half = r_addr[1] ? r_rdata[31:16] : r_rdata[15:0];
   end

   // funct3[2] selects zero extension (BU/HU).
   always_comb begin
      o_rData = '0;
      if ((r_state == RESP) && !r_we) begin
         case (r_funct3[1:0])
            2'b00:   o_rData = {{24{!r_funct3[2] && w_byte[7]}}, w_byte};
            2'b01:   o_rData = {{16{!r_funct3[2] && w_half[15]}}, w_half};
            default: o_rData = r_rdata;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads with extension, stores with lane replication,
// misalignment, bus timeout and reset in the middle of an access.
module tb_load_store_unit;
   logic        i_Clk;
   logic        i_Reset;
   logic        i_MemRead;
   logic        i_MemWrite;
   logic [2:0]  i_funct3;
   logic [31:0] i_Addr;
   logic [31:0] i_wData;
   logic [31:0] o_rData;
   logic        o_Stall;
   logic        o_Done;
   logic        o_MisalignErr;
   logic        o_BusErr;

   int checks = 0;
   int errors = 0;

   load_store_unit_if bus ();

   load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
      .i_Clk         (i_Clk),
      .i_Reset       (i_Reset),
      .i_MemRead     (i_MemRead),
      .i_MemWrite    (i_MemWrite),
      .i_funct3      (i_funct3),
      .i_Addr        (i_Addr),
      .i_wData       (i_wData),
      .o_rData       (o_rData),
      .o_Stall       (o_Stall),
      .o_Done        (o_Done),
      .o_MisalignErr (o_MisalignErr),
      .o_BusErr      (o_BusErr),
      .bus           (bus.master)
   );

   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_Clk);
      #1;
   endtask

   // Full access with ready in the first BUSY cycle; called #1 after a clock edge.
   task automatic do_access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd, input logic [31:0] exp_rd);
      i_MemRead  = rd;
      i_MemWrite = wr;
      i_funct3   = f3;
      i_Addr     = addr;
      i_wData    = wdata;
      #1;
      chk({tag, " stall_N"}, o_Stall, 1);
      chk({tag, " misalign_N"}, o_MisalignErr, 0);
      chk({tag, " busreq_N"}, bus.o_BusReq, 0);
      tick();
      chk({tag, " busreq_N1"}, bus.o_BusReq, 1);
      chk({tag, " busaddr"}, bus.o_BusAddr, exp_addr);
      chk({tag, " be"}, bus.o_BusBE, exp_be);
      chk({tag, " we"}, bus.o_BusWe, wr);
      chk({tag, " wdata"}, bus.o_BusWData, exp_wd);
      chk({tag, " stall_N1"}, o_Stall, 1);
      bus.i_BusReady = 1'b1;
      bus.i_BusRData = rdata;
      tick();
      bus.i_BusReady = 1'b0;
      chk({tag, " done_N2"}, o_Done, 1);
      chk({tag, " rdata_N2"}, o_rData, exp_rd);
      chk({tag, " stall_N2"}, o_Stall, 0);
      chk({tag, " buserr_N2"}, o_BusErr, 0);
      chk({tag, " busreq_N2"}, bus.o_BusReq, 0);
      i_MemRead  = 1'b0;
      i_MemWrite = 1'b0;
      tick();
      chk({tag, " done_N3"}, o_Done, 0);
      chk({tag, " rdata_N3"}, o_rData, 0);
      chk({tag, " busreq_N3"}, bus.o_BusReq, 0);
   endtask

   initial begin
      int n;
      i_Reset        = 1'b1;
      i_MemRead      = 1'b1;
      i_MemWrite     = 1'b0;
      i_funct3       = 3'b010;
      i_Addr         = 32'h0000_0100;
      i_wData        = 32'h0;
      bus.i_BusReady = 1'b0;
      bus.i_BusRData = 32'h0;

      // Reset held with a request pending: no stall, nothing on the bus.
      tick();
      tick();
      chk("rst stall", o_Stall, 0);
      chk("rst busreq", bus.o_BusReq, 0);
      chk("rst done", o_Done, 0);
      chk("rst buserr", o_BusErr, 0);
      chk("rst rdata", o_rData, 0);
      i_MemRead = 1'b0;
      i_Reset   = 1'b0;
      tick();

      // Ready outside BUSY has no effect.
      bus.i_BusReady = 1'b1;
      tick();
      chk("idle ready busreq", bus.o_BusReq, 0);
      chk("idle ready done", o_Done, 0);
      bus.i_BusReady = 1'b0;

      do_access("LW100", 1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF,
                32'h0000_0100, 4'b1111, 32'h0, 32'hDEAD_BEEF);
      do_access("LB103", 1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234,
                32'h0000_0100, 4'b1000, 32'h0, 32'hFFFF_FF80);
      do_access("LBU103", 1, 0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_1234,
                32'h0000_0100, 4'b1000, 32'h0, 32'h0000_0080);
      do_access("LHU102", 1, 0, 3'b101, 32'h0000_0102, 32'h0, 32'h80FF_1234,
                32'h0000_0100, 4'b1100, 32'h0, 32'h0000_80FF);
      do_access("LH102", 1, 0, 3'b001, 32'h0000_0102, 32'h0, 32'h80FF_1234,
                32'h0000_0100, 4'b1100, 32'h0, 32'hFFFF_80FF);
      do_access("LB101", 1, 0, 3'b000, 32'h0000_0101, 32'h0, 32'h80FF_1234,
                32'h0000_0100, 4'b0010, 32'h0, 32'h0000_0012);
      do_access("LH100", 1, 0, 3'b001, 32'h0000_0100, 32'h0, 32'h80FF_9234,
                32'h0000_0100, 4'b0011, 32'h0, 32'hFFFF_9234);
      do_access("SB201", 0, 1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'h5555_5555,
                32'h0000_0200, 4'b0010, 32'hABAB_ABAB, 32'h0);
      do_access("SH202", 0, 1, 3'b001, 32'h0000_0202, 32'hFFFF_1234, 32'h5555_5555,
                32'h0000_0200, 4'b1100, 32'h1234_1234, 32'h0);
      do_access("SWrdwr", 1, 1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'h5555_5555,
                32'h0000_0204, 4'b1111, 32'hCAFE_F00D, 32'h0);

      // Misaligned word and half: flagged the same cycle, no bus access.
      i_MemRead = 1'b1;
      i_funct3  = 3'b010;
      i_Addr    = 32'h0000_0102;
      #1;
      chk("misW err", o_MisalignErr, 1);
      chk("misW stall", o_Stall, 0);
      chk("misW rdata", o_rData, 0);
      tick();
      chk("misW busreq", bus.o_BusReq, 0);
      chk("misW done", o_Done, 0);
      i_funct3 = 3'b101;
      i_Addr   = 32'h0000_0103;
      #1;
      chk("misH err", o_MisalignErr, 1);
      chk("misH stall", o_Stall, 0);
      i_funct3 = 3'b000;
      #1;
      chk("byte odd no err", o_MisalignErr, 0);
      i_MemRead = 1'b0;
      tick();
      chk("misH busreq", bus.o_BusReq, 0);

      // Timeout: bus never ready.
      i_MemRead = 1'b1;
      i_funct3  = 3'b010;
      i_Addr    = 32'h0000_0300;
      tick();
      n = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.o_BusReq !== 1'b1) break;
         n++;
         tick();
      end
      chk("tmo busreq cycles", n, 16);
      chk("tmo buserr", o_BusErr, 1);
      chk("tmo done", o_Done, 1);
      chk("tmo rdata", o_rData, 0);
      chk("tmo stall", o_Stall, 0);
      i_MemRead = 1'b0;
      tick();
      chk("tmo buserr clear", o_BusErr, 0);
      chk("tmo done clear", o_Done, 0);

      // Reset on the third BUSY cycle aborts the access.
      i_MemRead = 1'b1;
      i_funct3  = 3'b010;
      i_Addr    = 32'h0000_0400;
      tick();
      tick();
      tick();
      chk("abort busy3 busreq", bus.o_BusReq, 1);
      i_Reset = 1'b1;
      #1;
      chk("abort stall in reset", o_Stall, 0);
      tick();
      i_Reset   = 1'b0;
      i_MemRead = 1'b0;
      #1;
      chk("abort busreq", bus.o_BusReq, 0);
      chk("abort done", o_Done, 0);
      tick();
      chk("abort no done later", o_Done, 0);
      chk("abort still idle", bus.o_BusReq, 0);

      do_access("LWpost", 1, 0, 3'b010, 32'h0000_0408, 32'h0, 32'h0123_4567,
                32'h0000_0408, 4'b1111, 32'h0, 32'h0123_4567);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach the end, observed timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of BUSY cycles to wait for i_BusReady.
REQ-002 SHALL have port i_Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_Reset, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port i_MemRead, input, 1, load request from the datapath; held until the request completes.
REQ-005 SHALL have port i_MemWrite, input, 1, store request from the datapath; held until the request completes.
REQ-006 SHALL have port i_funct3, input, 3, access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port i_Addr, input, 32, byte address (ALU result).
REQ-008 SHALL have port i_wData, input, 32, store data (rs2), right-aligned.
REQ-009 SHALL have port o_rData, output, 32, load result, extended.
REQ-010 SHALL have port o_Stall, output, 1, hold PC and register-file write.
REQ-011 SHALL have port o_Done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port o_MisalignErr, output, 1, misaligned-access pulse.
REQ-013 SHALL have port o_BusErr, output, 1, timeout pulse.
REQ-014 SHALL have bus ports o_BusReq (1), o_BusWe (1), o_BusAddr (32), o_BusWData (32), o_BusBE (4), i_BusReady (1) and i_BusRData (32).

Function
REQ-015 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-016 SHALL treat a request as i_MemRead|i_MemWrite; when both are asserted, the access SHALL be a store.
REQ-017 SHALL, in IDLE, flag a request as misaligned when it is H/HU with i_Addr[0]=1, or W with i_Addr[1:0]!=0.
REQ-018 SHALL, in IDLE with an aligned request, register addr, we, BE, shifted wData and funct3, then move to BUSY.
REQ-019 SHALL, in IDLE with a misaligned request, assert o_MisalignErr combinationally for that cycle, set o_Stall=0 and o_rData=0, issue no bus access, and stay in IDLE.
REQ-020 SHALL drive o_Stall combinationally as (IDLE & aligned request) | BUSY; o_Stall SHALL be 0 in RESP.
REQ-021 SHALL, in BUSY, drive o_BusReq=1 with stable registered addr/we/BE/wData.
REQ-022 SHALL drive o_BusAddr = {addr[31:2],2'b00}.
REQ-023 SHALL generate BE as follows: B gives 1<<addr[1:0]; H gives 0011 (addr[1]=0) or 1100; W gives 1111.
REQ-024 SHALL replicate store data across lanes: B gives {4{wData[7:0]}}; H gives {2{wData[15:0]}}; W is unchanged.
REQ-025 SHALL, in BUSY with i_BusReady=1, capture i_BusRData and move to RESP.
REQ-026 SHALL count BUSY cycles; if the count reaches TIMEOUT_CYCLES without i_BusReady, it SHALL drop o_BusReq, set the captured data to 0, pulse o_BusErr in RESP, and move to RESP.
REQ-027 SHALL, in RESP, pulse o_Done=1, drive o_Stall=0, and drive o_rData from the selected lane: B/BU sign/zero-extend byte addr[1:0]; H/HU extend half addr[1]; W passes through; stores give 0.
REQ-028 SHALL always move from RESP to IDLE; the still-asserted request during RESP SHALL NOT start a new access.
REQ-029 SHALL give minimum latency as follows: request seen in cycle N, ready in N+1, o_Done in N+2; o_Stall is high for cycles N and N+1.
REQ-030 SHALL drive o_rData=0 outside RESP.
REQ-031 SHALL ignore i_BusReady outside BUSY.

Reset
REQ-032 SHALL, on i_Reset=1 at a clock edge, set the state to IDLE, clear the counter and captured data, and drive o_BusReq=0, o_Done=0, o_BusErr=0 and o_rData=0 from the next cycle.
REQ-033 SHALL abort an access when reset occurs mid-access (BUSY or RESP) with no o_Done pulse; the bus SHALL see o_BusReq fall after that edge.
REQ-034 SHALL drive o_Stall=0 while i_Reset=1, regardless of request.

Verification
REQ-035 SHALL be verified by the scenario: LW at 0x100 with i_BusReady in the first BUSY cycle and i_BusRData=0xDEADBEEF -> o_BusAddr=0x100, BE=1111, o_Done at N+2, o_rData=0xDEADBEEF, 2 stall cycles.
REQ-036 SHALL be verified by the scenario: LB at 0x103 with RData=0x80FF1234 -> o_rData=0xFFFFFF80; LBU at the same address -> 0x00000080; LHU at 0x102 -> 0x000080FF.
REQ-037 SHALL be verified by the scenario: SB at 0x201 with wData=0x000000AB -> o_BusWe=1, BE=0010, o_BusWData=0xABABABAB, o_BusAddr=0x200.
REQ-038 SHALL be verified by the scenario: LW at 0x102 -> o_MisalignErr=1 the same cycle, o_BusReq stays 0, o_Stall=0.
REQ-039 SHALL be verified by the scenario: LW with i_BusReady never asserted and TIMEOUT_CYCLES=16 -> o_BusReq high for 16 cycles, then o_BusErr=1 and o_Done=1 together, o_rData=0.
REQ-040 SHALL be verified by the scenario: i_Reset=1 on the 3rd BUSY cycle -> o_BusReq=0 and state IDLE next cycle, no o_Done; a new LW issued afterwards completes normally.
